// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions for the receive and transmit paths.
//   - rx_state_t              : receiver FSM state encoding
//   - UART_DATA_BITS          : payload bits per frame
//   - UART_DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   - UART_CLKS_*             : baud table (clocks per bit at UART_CLK_HZ)
//   - uart_even_parity()      : even-parity bit for one data byte
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLK_HZ               = 50_000_000;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  // Baud table shared with the transmitter (clocks per bit at UART_CLK_HZ).
  localparam int UART_CLKS_9600   = 5208;
  localparam int UART_CLKS_19200  = 2604;
  localparam int UART_CLKS_57600  = 868;
  localparam int UART_CLKS_115200 = 434;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic uart_even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Single-bit two-flop synchroniser for asynchronous inputs.
//   Parameter RST_VAL sets the value both flops take during reset, so an
//   idle-high line does not look like an edge when reset is released.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   d    in  asynchronous input
//   q    out synchronised output (two clk edges of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  // Next values: shift the input through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops with synchronous reset to RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_char.sv
// uart_rx_char
//   Serial receive stage for the character display path. Deserialises
//   asynchronous 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from
//   `rx` and holds the last good byte on `data_out`, which feeds the
//   ASCII-to-7-segment decoder combinationally.
// Configuration macro: UART_RX_PARITY_EN
//   defined   : even-parity bit between data and stop, parity_err live
//   undefined : 10-bit frames, parity_err tied to 0
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit, legal 4..65535
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   rx          in   asynchronous serial input, idle high
//   data_out    out  [7:0] last correctly received byte (reset 8'h00)
//   data_valid  out  one-cycle pulse when data_out updates
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on parity mismatch
module uart_rx_char
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      parity_err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rx_s;

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic                      par_bad_q, par_bad_d;

  // Frame outcome decided at the stop-bit sample point; the output stage
  // turns it into the visible strobes one edge later.
  logic ev_valid_q, ev_valid_d;
  logic ev_ferr_q, ev_ferr_d;

  logic [UART_DATA_BITS-1:0] data_out_q, data_out_d;
  logic                      data_valid_q, data_valid_d;
  logic                      frame_err_q, frame_err_d;

`ifdef UART_RX_PARITY_EN
  logic ev_perr_q, ev_perr_d;
  logic parity_err_q, parity_err_d;
`endif

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Receiver FSM: bit timing, data shifting and frame outcome decision.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_bad_d  = par_bad_q;
    ev_valid_d = 1'b0;
    ev_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    ev_perr_d  = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rx_s) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end

      RX_START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d   = RX_DATA;
            idx_d     = 3'd0;
            par_bad_d = 1'b0;
          end
        end else begin
          state_d = RX_START;
        end
      end

      RX_DATA: begin
        // Sampling a full bit period after mid start keeps every sample
        // near the centre of its bit.
        if (cnt_q == CNT_LAST) begin
          cnt_d          = CNT_ZERO;
          shreg_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_DATA;
        end
      end

      RX_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_q == CNT_LAST) begin
          cnt_d     = CNT_ZERO;
          par_bad_d = uart_even_parity(shreg_q) ^ rx_s;
          state_d   = RX_STOP;
        end else begin
          state_d = RX_PARITY;
        end
`else
        // Unreachable in this build; recover to IDLE if ever entered.
        cnt_d   = CNT_ZERO;
        state_d = RX_IDLE;
`endif
      end

      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s) begin
            state_d = RX_IDLE;
            if (par_bad_q) begin
`ifdef UART_RX_PARITY_EN
              ev_perr_d = 1'b1;
`endif
            end else begin
              ev_valid_d = 1'b1;
            end
          end else begin
            // A low stop bit may be a line break: wait for the line to go
            // idle rather than decoding the held-low line as new frames.
            ev_ferr_d = 1'b1;
            state_d   = RX_BREAK;
          end
        end else begin
          state_d = RX_STOP;
        end
      end

      RX_BREAK: begin
        cnt_d = CNT_ZERO;
        if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_BREAK;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = RX_IDLE;
      end
    endcase

`ifndef UART_RX_PARITY_EN
    par_bad_d = 1'b0;
`endif
  end

  // Output stage: registered strobes and the held data byte. shreg is
  // untouched outside DATA, so it still holds the frame one edge later.
  always_comb begin
    data_valid_d = ev_valid_q;
    frame_err_d  = ev_ferr_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = ev_perr_q;
`endif
    if (ev_valid_q) begin
      data_out_d = shreg_q;
    end else begin
      data_out_d = data_out_q;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RX_IDLE;
      cnt_q        <= CNT_ZERO;
      idx_q        <= 3'd0;
      shreg_q      <= 8'h00;
      par_bad_q    <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_ferr_q    <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ev_perr_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_bad_q    <= par_bad_d;
      ev_valid_q   <= ev_valid_d;
      ev_ferr_q    <= ev_ferr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      ev_perr_q    <= ev_perr_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_char.sv
// tb_uart_rx_char
//   Self-checking bench for uart_rx_char with CLKS_PER_BIT = 16.
//   Frames are driven bit by bit; the expected strobe kind, edge and byte
//   for every frame come from the frame rules and the latency formula
//   E0 + 3 + H + (9 or 10)*B, and are compared with what the monitor saw.
module tb_uart_rx_char;

  localparam int B = 16;
  localparam int H = B / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int PAYLOAD_BITS = 10;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int PAYLOAD_BITS = 9;
`endif
  localparam int FRAME_CYC = (PAYLOAD_BITS + 1) * B;

  localparam int K_VALID = 1;
  localparam int K_FERR  = 2;
  localparam int K_PERR  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int got_kind[$];
  int got_cyc[$];
  int got_data[$];
  int exp_kind[$];
  int exp_cyc[$];
  int exp_data[$];

  logic [7:0] model_data = 8'h00;
  bit         last_bad_stop = 1'b0;

  uart_rx_char #(
    .CLKS_PER_BIT (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record every strobe seen, away from the active edge.
  always @(negedge clk) begin
    if (data_valid || frame_err || parity_err) begin
      check("strobe_onehot", 32'(data_valid) + 32'(frame_err) + 32'(parity_err), 32'd1);
      got_kind.push_back(data_valid ? K_VALID : (frame_err ? K_FERR : K_PERR));
      got_cyc.push_back(cyc);
      got_data.push_back(int'(data_out));
    end
  end

  task automatic idle(input int n);
    if (n > 0) begin
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (B) @(posedge clk);
    #1;
  endtask

  // Drive one frame and record what the receiver must report for it.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    int   e0;
    int   ones;
    logic pbit;
    e0   = cyc + 1;
    ones = 0;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_bit(b[i]);
      ones += int'(b[i]);
    end
    // Even parity: the parity bit makes the number of ones even.
    pbit = ((ones % 2) == 1) ? 1'b1 : 1'b0;
    if (PAR_EN) begin
      drive_bit(par_ok ? pbit : ~pbit);
    end
    drive_bit(stop_ok);
    exp_cyc.push_back(e0 + 3 + H + PAYLOAD_BITS * B);
    if (!stop_ok) begin
      exp_kind.push_back(K_FERR);
    end else if (PAR_EN && !par_ok) begin
      exp_kind.push_back(K_PERR);
    end else begin
      exp_kind.push_back(K_VALID);
      model_data = b;
    end
    exp_data.push_back(int'(model_data));
    last_bad_stop = !stop_ok;
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, got_kind.size(), exp_kind.size());
    for (int i = 0; i < got_kind.size() && i < exp_kind.size(); i++) begin
      check({tag, "_kind"}, got_kind[i], exp_kind[i]);
      check({tag, "_cycle"}, got_cyc[i], exp_cyc[i]);
      check({tag, "_data"}, got_data[i], exp_data[i]);
    end
    check({tag, "_data_out"}, 32'(data_out), 32'(model_data));
    got_kind.delete(); got_cyc.delete(); got_data.delete();
    exp_kind.delete(); exp_cyc.delete(); exp_data.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    rst = 1'b0;
    idle(2 * B);

    // Single good frame 'A'.
    send_frame(8'h41, 1'b1, 1'b1);
    idle(2 * B);
    verify("frame_41");

    // Back-to-back frames with no idle gap.
    send_frame(8'h30, 1'b1, 1'b1);
    send_frame(8'h39, 1'b1, 1'b1);
    idle(2 * B);
    if (got_cyc.size() >= 2) begin
      check("b2b_spacing", got_cyc[1] - got_cyc[0], FRAME_CYC);
    end else begin
      check("b2b_pulses", got_cyc.size(), 2);
    end
    verify("b2b");

    // Bad stop bit followed by a long break.
    send_frame(8'h35, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (40 * B) @(posedge clk);
    #1;
    idle(2 * B);
    verify("break");

    // Short low glitch on the idle line.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(2 * B);
    verify("glitch");

    // Reset in the middle of the data bits of 8'h46.
    begin
      logic [7:0] b;
      b = 8'h46;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      rst = 1'b1;
      rx  = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_data = 8'h00;
      check("midframe_rst_data_out", 32'(data_out), 32'h00);
      idle(12 * B);
      verify("midframe_rst");
    end

    send_frame(8'h43, 1'b1, 1'b1);
    idle(2 * B);
    verify("after_rst");

    if (PAR_EN) begin
      send_frame(8'h37, 1'b1, 1'b0);
      idle(2 * B);
      verify("parity_bad");
      send_frame(8'h37, 1'b1, 1'b1);
      idle(2 * B);
      verify("parity_good");
    end

    // Randomised frames, gaps, stop bits and parity.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         s_ok;
      bit         p_ok;
      b    = 8'($urandom);
      s_ok = ($urandom_range(0, 5) != 0);
      p_ok = ($urandom_range(0, 4) != 0);
      if (last_bad_stop) begin
        idle($urandom_range(8, 40));
      end else begin
        idle($urandom_range(0, 40));
      end
      send_frame(b, s_ok, p_ok);
    end
    idle(3 * B);
    verify("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
